sdes_round_engine: RTL and testbench

// - Iterative S-DES block engine: IP -> fk(K1) -> SW -> fk(K2) -> IP^-1, one fk round per clock.
// - Each round is E/P -> XOR subkey -> S0_Box/S1_Box -> P4 -> XOR left nibble.
// - The round datapath feeds S0_Box/S1_Box (E/P^K nibbles) and consumes their 2-bit outputs (P4).
// - Sits between the byte-stream front end and the result buffer. Valid/ready on both sides.

---
 rtl/sdes_round_engine.sv | 207 ++++++++++++++++++++
 tb/tb_sdes_round_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdes_round_engine.sv
`default_nettype none
// sdes_round_engine: iterative S-DES, IP -> fk(Ka) -> SW -> fk(Kb) -> IP^-1, one fk round per clock.
// Defining SDES_KEY_CACHE_EN adds key_load and a cached K1/K2 schedule.

module sdes_s0_box (
  input  logic [0:3] din,
  output logic [0:1] dout
);
  // Row is outer bits (1,4), column is inner bits (2,3).
  always_comb begin
    dout = 2'd0;
    case ({din[0], din[3], din[1], din[2]})
      4'd0:  dout = 2'd1;
      4'd1:  dout = 2'd0;
      4'd2:  dout = 2'd3;
      4'd3:  dout = 2'd2;
      4'd4:  dout = 2'd3;
      4'd5:  dout = 2'd2;
      4'd6:  dout = 2'd1;
      4'd7:  dout = 2'd0;
      4'd8:  dout = 2'd0;
      4'd9:  dout = 2'd2;
      4'd10: dout = 2'd1;
      4'd11: dout = 2'd3;
      4'd12: dout = 2'd3;
      4'd13: dout = 2'd1;
      4'd14: dout = 2'd3;
      4'd15: dout = 2'd2;
      default: dout = 2'd0;
    endcase
  end
endmodule

module sdes_s1_box (
  input  logic [0:3] din,
  output logic [0:1] dout
);
  always_comb begin
    dout = 2'd0;
    case ({din[0], din[3], din[1], din[2]})
      4'd0:  dout = 2'd0;
      4'd1:  dout = 2'd1;
      4'd2:  dout = 2'd2;
      4'd3:  dout = 2'd3;
      4'd4:  dout = 2'd2;
      4'd5:  dout = 2'd0;
      4'd6:  dout = 2'd1;
      4'd7:  dout = 2'd3;
      4'd8:  dout = 2'd3;
      4'd9:  dout = 2'd0;
      4'd10: dout = 2'd1;
      4'd11: dout = 2'd0;
      4'd12: dout = 2'd2;
      4'd13: dout = 2'd1;
      4'd14: dout = 2'd0;
      4'd15: dout = 2'd3;
      default: dout = 2'd0;
    endcase
  end
endmodule

module sdes_round_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:7] in_block,
  input  logic [0:9] in_key,
  input  logic       in_decrypt,
`ifdef SDES_KEY_CACHE_EN
  input  logic       key_load,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [0:7] out_block
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    R1   = 2'd1,
    R2   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  function automatic logic [0:7] p8(input logic [0:9] x);
    return {x[5], x[2], x[6], x[3], x[7], x[4], x[9], x[8]};
  endfunction

  // Returns {K1, K2}; K2 uses two further left rotations of each half.
  function automatic logic [0:15] key_sched(input logic [0:9] k);
    logic [0:9] p;
    logic [0:4] l1, r1, l2, r2;
    p  = {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
    l1 = {p[1:4], p[0]};
    r1 = {p[6:9], p[5]};
    l2 = {l1[2:4], l1[0:1]};
    r2 = {r1[2:4], r1[0:1]};
    return {p8({l1, r1}), p8({l2, r2})};
  endfunction

  function automatic logic [0:7] ip(input logic [0:7] b);
    return {b[1], b[5], b[2], b[0], b[3], b[7], b[4], b[6]};
  endfunction

  function automatic logic [0:7] ip_inv(input logic [0:7] b);
    return {b[3], b[0], b[2], b[4], b[6], b[1], b[7], b[5]};
  endfunction

  function automatic logic [0:7] ep(input logic [0:3] x);
    return {x[3], x[0], x[1], x[2], x[1], x[2], x[3], x[0]};
  endfunction

  function automatic logic [0:3] p4(input logic [0:3] s);
    return {s[1], s[3], s[2], s[0]};
  endfunction

  logic [0:3]  l, r;
  logic [0:7]  ka, kb;
  logic [0:7]  k1_new, k2_new, k1_use, k2_use;
  logic [0:7]  round_key, ep_x;
  logic [0:1]  s0_out, s1_out;
  logic [0:3]  f_out, l_mixed;

  assign {k1_new, k2_new} = key_sched(in_key);

`ifdef SDES_KEY_CACHE_EN
  logic [0:7] k1_cache, k2_cache;

  always_ff @(posedge clk) begin
    if (rst) begin
      k1_cache <= 8'h00;
      k2_cache <= 8'h00;
    end else if (state == IDLE && key_load) begin
      k1_cache <= k1_new;
      k2_cache <= k2_new;
    end
  end

  // A key loaded in the same cycle as a block takes effect for that block.
  assign k1_use = key_load ? k1_new : k1_cache;
  assign k2_use = key_load ? k2_new : k2_cache;
`else
  assign k1_use = k1_new;
  assign k2_use = k2_new;
`endif

  assign round_key = (state == R1) ? ka : kb;
  assign ep_x      = ep(r) ^ round_key;

  sdes_s0_box u_s0 (.din(ep_x[0:3]), .dout(s0_out));
  sdes_s1_box u_s1 (.din(ep_x[4:7]), .dout(s1_out));

  assign f_out   = p4({s0_out, s1_out});
  assign l_mixed = l ^ f_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = R1;
      end
      R1:   state_nxt = R2;
      R2:   state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l         <= 4'h0;
      r         <= 4'h0;
      ka        <= 8'h00;
      kb        <= 8'h00;
      out_block <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {l, r} <= ip(in_block);
          ka     <= in_decrypt ? k2_use : k1_use;
          kb     <= in_decrypt ? k1_use : k2_use;
        end
        R1: begin
          l <= r;
          r <= l_mixed;
        end
        R2: begin
          l         <= l_mixed;
          out_block <= ip_inv({l_mixed, r});
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sdes_round_engine.sv
`default_nettype none
// tb_sdes_round_engine: scoreboard bench for sdes_round_engine with an independent table-driven S-DES model.

module tb_sdes_round_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [0:7] in_block = 8'h00;
  logic [0:9] in_key = 10'h000;
  logic       in_decrypt = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [0:7] out_block;
`ifdef SDES_KEY_CACHE_EN
  logic       key_load = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [0:7] exp_q[$];
  int         acc_q[$];
  int         last_acc = -1;

  int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  int P8_T[8]   = '{6, 3, 7, 4, 8, 5, 10, 9};
  int IP_T[8]   = '{2, 6, 3, 1, 4, 8, 5, 7};
  int IPI_T[8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  int EP_T[8]   = '{4, 1, 2, 3, 2, 3, 4, 1};
  int P4_T[4]   = '{2, 4, 3, 1};
  int S0_T[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int S1_T[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  sdes_round_engine dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_block(in_block),
    .in_key(in_key),
    .in_decrypt(in_decrypt),
`ifdef SDES_KEY_CACHE_EN
    .key_load(key_load),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:8] fk(input logic [1:8] x, input logic [1:8] k);
    logic [1:8] e;
    logic [1:4] s, p;
    int r0, c0, r1, c1, v0, v1;
    for (int i = 0; i < 8; i++) e[i+1] = x[4 + EP_T[i]] ^ k[i+1];
    r0 = 2 * int'(e[1]) + int'(e[4]);
    c0 = 2 * int'(e[2]) + int'(e[3]);
    r1 = 2 * int'(e[5]) + int'(e[8]);
    c1 = 2 * int'(e[6]) + int'(e[7]);
    v0 = S0_T[r0][c0];
    v1 = S1_T[r1][c1];
    s[1] = v0[1]; s[2] = v0[0]; s[3] = v1[1]; s[4] = v1[0];
    for (int i = 0; i < 4; i++) p[i+1] = s[P4_T[i]];
    return {x[1:4] ^ p, x[5:8]};
  endfunction

  function automatic logic [1:8] sdes_model(input logic [1:8] pt, input logic [1:10] key, input logic dec);
    logic [1:10] p, s1, s3;
    logic [1:8]  k1, k2, x, t;
    for (int i = 0; i < 10; i++) p[i+1] = key[P10_T[i]];
    for (int i = 0; i < 5; i++) begin
      s1[i+1] = p[((i + 1) % 5) + 1];
      s1[i+6] = p[((i + 1) % 5) + 6];
      s3[i+1] = p[((i + 3) % 5) + 1];
      s3[i+6] = p[((i + 3) % 5) + 6];
    end
    for (int i = 0; i < 8; i++) begin
      k1[i+1] = s1[P8_T[i]];
      k2[i+1] = s3[P8_T[i]];
    end
    for (int i = 0; i < 8; i++) x[i+1] = pt[IP_T[i]];
    x = fk(x, dec ? k2 : k1);
    x = {x[5:8], x[1:4]};
    x = fk(x, dec ? k1 : k2);
    for (int i = 0; i < 8; i++) t[i+1] = x[IPI_T[i]];
    return t;
  endfunction

  // Monitor: latency, back-pressure stability, in_ready exclusion and result comparison.
  initial begin
    logic       prev_valid;
    logic       prev_taken;
    logic [0:7] prev_block;
    logic [0:7] e;
    prev_valid = 1'b0;
    prev_taken = 1'b0;
    prev_block = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_while_valid: got %0b, want 0", in_ready);
        end
        if (!prev_valid) begin
          checks++;
          if (acc_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: block %b with nothing outstanding", out_block);
          end else if (cyc - acc_q[0] != 2) begin
            errors++;
            $display("FAIL latency: %0d edges after accept edge, want 2", cyc - acc_q[0]);
          end
        end else if (!prev_taken) begin
          checks++;
          if (out_block !== prev_block) begin
            errors++;
            $display("FAIL backpressure_hold: got %b, want %b", out_block, prev_block);
          end
        end
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got %b, queue empty", out_block);
          end else begin
            e = exp_q.pop_front();
            if (acc_q.size() != 0) void'(acc_q.pop_front());
            if (out_block !== e) begin
              errors++;
              $display("FAIL result: got %b, want %b", out_block, e);
            end
          end
        end
      end
      prev_valid = out_valid;
      prev_taken = out_valid && out_ready;
      prev_block = out_block;
    end
  end

  task automatic send(input logic [0:7] b, input logic [0:9] k, input logic dec,
                      input logic [0:7] expv, input logic check_gap);
    int n;
    @(negedge clk);
    in_block   = b;
    in_key     = k;
    in_decrypt = dec;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc + 1);
      if (check_gap && last_acc >= 0) begin
        checks++;
        if (cyc + 1 - last_acc != 4) begin
          errors++;
          $display("FAIL accept_spacing: got %0d clocks, want 4", cyc + 1 - last_acc);
        end
      end
      last_acc = cyc + 1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:7] b, c, held;
    logic [0:9] k;
    int n, seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_block=%b, want 1 0 00000000",
               in_ready, out_valid, out_block);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Reference vectors
    send(8'b10010111, 10'b1010000010, 1'b0, 8'b00111000, 1'b0);
    drain();
    send(8'b00111000, 10'b1010000010, 1'b1, 8'b10010111, 1'b0);
    drain();

    // Back-pressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'b10010111, 10'b1010000010, 1'b0, 8'b00111000, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_valid_timeout: out_valid=%0b, want 1", out_valid);
    end
    held = out_block;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_block !== 8'b00111000) begin
      errors++;
      $display("FAIL bp_held: out_valid=%0b out_block=%b, want 1 00111000", out_valid, out_block);
    end
    checks++;
    if (out_block !== held) begin
      errors++;
      $display("FAIL bp_stable: got %b, want %b", out_block, held);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b, want 0 1", out_valid, in_ready);
    end
    drain();

    // Reset while in R1: the in-flight block is discarded
    send(8'b01010101, 10'b1100110011, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_r1: in_ready=%0b out_valid=%0b out_block=%b, want 1 0 00000000",
               in_ready, out_valid, out_block);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted_block: out_valid seen %0d cycles, want 0", seen);
    end

    // Streaming: encrypt then decrypt the ciphertext back to the original
    last_acc = -1;
    for (int i = 0; i < 128; i++) begin
      b = 8'($urandom);
      k = 10'($urandom);
      c = sdes_model(b, k, 1'b0);
      send(b, k, 1'b0, c, 1'b1);
      send(c, k, 1'b1, b, 1'b1);
    end
    drain();

`ifdef SDES_KEY_CACHE_EN
    // Cached key ignores in_key
    @(negedge clk);
    in_key   = 10'b1010000010;
    key_load = 1'b1;
    @(posedge clk);
    #1 key_load = 1'b0;
    send(8'b10010111, 10'h3FF, 1'b0, 8'b00111000, 1'b0);
    drain();
    // key_load together with in_valid uses the new key
    @(negedge clk);
    key_load = 1'b1;
    send(8'b10010111, 10'h3FF, 1'b0, sdes_model(8'b10010111, 10'h3FF, 1'b0), 1'b0);
    key_load = 1'b0;
    drain();
    send(8'b01100110, 10'h000, 1'b0, sdes_model(8'b01100110, 10'h3FF, 1'b0), 1'b0);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
